// File: rtl/fpu_ctrl_pkg.sv
// Shared decode constants, decode result struct and controller state type
// for the FPU issue controller.
package fpu_ctrl_pkg;

    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    // OP-FP groups whose destination is an integer register
    localparam logic [4:0] F5_FCMP   = 5'b10100;
    localparam logic [4:0] F5_FCVT_W = 5'b11000;
    localparam logic [4:0] F5_FMV_X  = 5'b11100;

    typedef struct packed {
        logic rd_fs1;
        logic rd_fs2;
        logic rd_fs3;
        logic wr_fd;
        logic supported;
    } decode_t;

    localparam logic [0:0] ST_RUN_ENC   = 1'b0;
    localparam logic [0:0] ST_DRAIN_ENC = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } state_e;

endpackage

// File: rtl/fpu_issue_ctrl_decode.sv
// Combinational RV32F decode: which FP registers an instruction reads and
// whether it writes an FP destination.
module fpu_instr_decode
    import fpu_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0] opcode;
    logic [4:0] funct5;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct5      = instr[31:27];
    assign unused_bits = ^{instr[26:7]};

    always_comb begin
        dec = '0;
        case (opcode)
            OP_FLW: begin
                dec.wr_fd     = 1'b1;
                dec.supported = 1'b1;
            end
            OP_FSW: begin
                dec.rd_fs2    = 1'b1;
                dec.supported = 1'b1;
            end
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
                dec.rd_fs1    = 1'b1;
                dec.rd_fs2    = 1'b1;
                dec.rd_fs3    = 1'b1;
                dec.wr_fd     = 1'b1;
                dec.supported = 1'b1;
            end
            OP_FP: begin
                dec.rd_fs1    = 1'b1;
                dec.rd_fs2    = 1'b1;
                dec.wr_fd     = !(funct5 == F5_FCMP || funct5 == F5_FCVT_W ||
                                  funct5 == F5_FMV_X);
                dec.supported = 1'b1;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: scoreboarded hazard check, id tracking, in-flight
// counting and flush/drain sequencing in front of an FPU pipeline model.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned PIPELINE_STAGES = 4,
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned NUM_REGS        = 32
) (
    input  logic                                   ck,
    input  logic                                   rst,
    input  logic                                   issue_valid,
    output logic                                   issue_ready,
    input  logic [31:0]                            issue_instr,
    input  logic [X_ID_WIDTH-1:0]                  issue_id,
    input  logic                                   flush,
    input  logic                                   fpu_ready,
    output logic                                   fpu_enable,
    output logic [31:0]                            fpu_instr,
    output logic [X_ID_WIDTH-1:0]                  fpu_id,
    input  logic                                   res_valid,
    input  logic [X_ID_WIDTH-1:0]                  res_id,
    output logic                                   illegal,
    output logic                                   spurious,
    output logic [$clog2(PIPELINE_STAGES+1)-1:0]   inflight,
    output logic                                   busy
);

    localparam int unsigned   CW           = $clog2(PIPELINE_STAGES + 1);
    localparam int unsigned   NUM_IDS      = 2 ** X_ID_WIDTH;
    localparam logic [CW-1:0] MAX_INFLIGHT = CW'(PIPELINE_STAGES);

    state_e              state;
    decode_t             dec;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_IDS-1:0]  tbl_valid;
    logic [NUM_IDS-1:0]  tbl_wr;
    logic [4:0]          tbl_fd [NUM_IDS];

    logic [4:0]    fd, fs1, fs2, fs3;
    logic          hazard;
    logic          accept;
    logic          do_issue;
    logic          retire_hit;
    logic [CW-1:0] inflight_next;

    fpu_instr_decode u_decode (
        .instr (issue_instr),
        .dec   (dec)
    );

    assign fd  = issue_instr[11:7];
    assign fs1 = issue_instr[19:15];
    assign fs2 = issue_instr[24:20];
    assign fs3 = issue_instr[31:27];

    always_comb begin
        hazard = tbl_valid[issue_id];
        if (dec.rd_fs1 && pending[fs1]) hazard = 1'b1;
        if (dec.rd_fs2 && pending[fs2]) hazard = 1'b1;
        if (dec.rd_fs3 && pending[fs3]) hazard = 1'b1;
        if (dec.wr_fd  && pending[fd])  hazard = 1'b1;
    end

    // Flush wins over a coincident issue; rst gates the combinational outputs.
    assign issue_ready = rst && (state == ST_RUN) && !flush && !hazard &&
                         (inflight < MAX_INFLIGHT) &&
                         (fpu_ready || !dec.supported);
    assign accept      = issue_valid && issue_ready;
    assign do_issue    = accept && dec.supported;
    assign fpu_enable  = do_issue;
    assign fpu_instr   = issue_instr;
    assign fpu_id      = issue_id;
    assign retire_hit  = res_valid && tbl_valid[res_id];
    assign busy        = (inflight != '0) || (state == ST_DRAIN);

    always_comb begin
        inflight_next = inflight;
        if (do_issue && !retire_hit && inflight != MAX_INFLIGHT)
            inflight_next = inflight + CW'(1);
        else if (!do_issue && retire_hit && inflight != '0)
            inflight_next = inflight - CW'(1);
    end

    // Issue and retire can never target the same id or fd in one cycle
    // (both are hazards), so clear-then-set ordering is safe.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            tbl_valid <= '0;
            tbl_wr    <= '0;
            for (int unsigned i = 0; i < NUM_IDS; i++)
                tbl_fd[i] <= '0;
        end else begin
            if (retire_hit) begin
                tbl_valid[res_id] <= 1'b0;
                if (tbl_wr[res_id])
                    pending[tbl_fd[res_id]] <= 1'b0;
            end
            if (do_issue) begin
                tbl_valid[issue_id] <= 1'b1;
                tbl_wr[issue_id]    <= dec.wr_fd;
                tbl_fd[issue_id]    <= fd;
                if (dec.wr_fd)
                    pending[fd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            inflight <= '0;
            illegal  <= 1'b0;
            spurious <= 1'b0;
        end else begin
            inflight <= inflight_next;
            illegal  <= accept && !dec.supported;
            spurious <= res_valid && !tbl_valid[res_id];
            case (state)
                ST_RUN:   if (flush) state <= ST_DRAIN;
                ST_DRAIN: if (inflight_next == '0) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule
